// File: rtl/mem_ctrl_if.sv
// Request/response handshake bundle for the two client ports (A fetch, B data) of mem_ctrl.
interface mem_ctrl_if #(
   parameter int unsigned AW = 15,
   parameter int unsigned DW = 16
);
   logic          a_req_valid;
   logic          a_req_ready;
   logic [AW-1:0] a_req_addr;
   logic          a_rsp_valid;
   logic          a_rsp_ready;
   logic [DW-1:0] a_rsp_data;

   logic          b_req_valid;
   logic          b_req_ready;
   logic          b_req_we;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_req_wdata;
   logic          b_rsp_valid;
   logic          b_rsp_ready;
   logic [DW-1:0] b_rsp_data;

   modport slave (
      input  a_req_valid, a_req_addr, a_rsp_ready,
      input  b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_rsp_ready,
      output a_req_ready, a_rsp_valid, a_rsp_data,
      output b_req_ready, b_rsp_valid, b_rsp_data
   );

   modport master (
      output a_req_valid, a_req_addr, a_rsp_ready,
      output b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_rsp_ready,
      input  a_req_ready, a_rsp_valid, a_rsp_data,
      input  b_req_ready, b_rsp_valid, b_rsp_data
   );
endinterface

// File: rtl/mem_ctrl.sv
// Two-port arbiter in front of a 1-cycle-latency synchronous RAM, one read outstanding.
// Define MEM_CTRL_RR_ARB_EN for round-robin arbitration; default is fixed B-over-A priority.
module mem_ctrl #(
   parameter int unsigned AW = 15,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   mem_ctrl_if.slave     bus,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_di,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_do
);
   typedef enum logic {StIdle, StPend} state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;  // 0: A, 1: B
   logic   owner_rdy, slot_free, a_elig, b_elig, grant_a, grant_b, b_read;

`ifdef MEM_CTRL_RR_ARB_EN
   logic rr_q, rr_d;  // 1: B was granted most recently

   always_ff @(posedge clk) begin
      rr_q <= rr_d;
   end
`endif

   always_ff @(posedge clk) begin
      state_q <= state_d;
      owner_q <= owner_d;
   end

   always_comb begin
      owner_rdy = owner_q ? bus.b_rsp_ready : bus.a_rsp_ready;
      slot_free = (state_q == StIdle) || owner_rdy;
      b_elig    = bus.b_req_valid && (bus.b_req_we || slot_free);
      a_elig    = bus.a_req_valid && slot_free;
`ifdef MEM_CTRL_RR_ARB_EN
      grant_b   = !rst && b_elig && (!a_elig || !rr_q);
      rr_d      = rr_q;
      if (rst) begin
         rr_d = 1'b0;
      end else if (grant_b) begin
         rr_d = 1'b1;
      end else if (a_elig) begin
         rr_d = 1'b0;
      end
`else
      grant_b   = !rst && b_elig;
`endif
      grant_a   = !rst && a_elig && !grant_b;
      b_read    = grant_b && !bus.b_req_we;
   end

   always_comb begin
      bus.a_req_ready = grant_a;
      bus.b_req_ready = grant_b;
      mem_we          = 1'b0;
      mem_re          = 1'b0;
      mem_addr        = '0;
      mem_di          = '0;
      if (grant_b) begin
         mem_we   = bus.b_req_we;
         mem_re   = !bus.b_req_we;
         mem_addr = bus.b_req_addr;
         mem_di   = bus.b_req_wdata;
      end else if (grant_a) begin
         mem_re   = 1'b1;
         mem_addr = bus.a_req_addr;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (rst) begin
         state_d = StIdle;
         owner_d = 1'b0;
      end else if (grant_a || b_read) begin
         state_d = StPend;
         owner_d = b_read;
      end else if (state_q == StPend && owner_rdy) begin
         state_d = StIdle;
      end
   end

   // Read data comes straight from the RAM read register, which only moves on mem_re.
   assign bus.a_rsp_valid = (state_q == StPend) && !owner_q;
   assign bus.b_rsp_valid = (state_q == StPend) && owner_q;
   assign bus.a_rsp_data  = mem_do;
   assign bus.b_rsp_data  = mem_do;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural synchronous RAM.
module tb_mem_ctrl;
   localparam int unsigned AW = 15;
   localparam int unsigned DW = 16;
`ifdef MEM_CTRL_RR_ARB_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_di;
   logic          mem_we;
   logic          mem_re;
   logic [DW-1:0] mem_do;
   logic [DW-1:0] ram [0:(1<<AW)-1];

   int n_tests;
   int n_fail;

   mem_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   mem_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .mem_addr (mem_addr),
      .mem_di   (mem_di),
      .mem_we   (mem_we),
      .mem_re   (mem_re),
      .mem_do   (mem_do)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_di;
      if (mem_re) mem_do <= ram[mem_addr];
   end

   task automatic clear_inputs();
      bus.a_req_valid = 1'b0;
      bus.a_req_addr  = '0;
      bus.a_rsp_ready = 1'b1;
      bus.b_req_valid = 1'b0;
      bus.b_req_we    = 1'b0;
      bus.b_req_addr  = '0;
      bus.b_req_wdata = '0;
      bus.b_rsp_ready = 1'b1;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus.b_req_valid = 1'b1;
      bus.b_req_we    = 1'b1;
      bus.b_req_addr  = addr;
      bus.b_req_wdata = data;
      @(negedge clk);
      bus.b_req_valid = 1'b0;
      bus.b_req_we    = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      bus.a_req_valid = 1'b1;
      bus.b_req_valid = 1'b1;
      bus.b_req_we    = 1'b1;
      #1;
      n_tests++;
      if ({bus.a_req_ready, bus.b_req_ready, mem_we, mem_re} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready_a/ready_b/we/re=%b want 0000",
                  {bus.a_req_ready, bus.b_req_ready, mem_we, mem_re});
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      n_tests++;
      if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_rsp_valid: got %b want 00", {bus.a_rsp_valid, bus.b_rsp_valid});
      end
   endtask

   task automatic test_write_read();
      apply_reset();
      bus.b_req_valid = 1'b1;
      bus.b_req_we    = 1'b1;
      bus.b_req_addr  = 15'h0005;
      bus.b_req_wdata = 16'h1234;
      #1;
      n_tests++;
      if (!(bus.b_req_ready === 1'b1 && mem_we === 1'b1 && mem_addr === 15'h0005 &&
            mem_di === 16'h1234 && mem_re === 1'b0)) begin
         n_fail++;
         $display("FAIL wr_issue: got rdy=%b we=%b re=%b addr=%h di=%h want 1 1 0 0005 1234",
                  bus.b_req_ready, mem_we, mem_re, mem_addr, mem_di);
      end
      @(negedge clk);
      bus.b_req_valid = 1'b0;
      bus.b_req_we    = 1'b0;
      bus.a_req_valid = 1'b1;
      bus.a_req_addr  = 15'h0005;
      #1;
      n_tests++;
      if (!(bus.a_req_ready === 1'b1 && mem_re === 1'b1 && mem_addr === 15'h0005)) begin
         n_fail++;
         $display("FAIL rd_issue: got rdy=%b re=%b addr=%h want 1 1 0005",
                  bus.a_req_ready, mem_re, mem_addr);
      end
      @(negedge clk);
      bus.a_req_valid = 1'b0;
      n_tests++;
      if (!(bus.a_rsp_valid === 1'b1 && bus.a_rsp_data === 16'h1234 &&
            bus.b_rsp_valid === 1'b0)) begin
         n_fail++;
         $display("FAIL wr_then_rd: got a_vld=%b data=%h b_vld=%b want 1 1234 0",
                  bus.a_rsp_valid, bus.a_rsp_data, bus.b_rsp_valid);
      end
      @(negedge clk);
      n_tests++;
      if (bus.a_rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rsp_retire: got a_vld=%b want 0", bus.a_rsp_valid);
      end
   endtask

   task automatic test_arbitration();
      logic exp_b;
      logic prev_b;
      apply_reset();
      do_write(15'h0020, 16'h2222);
      do_write(15'h0021, 16'h3333);
      apply_reset();
      bus.a_req_valid = 1'b1;
      bus.a_req_addr  = 15'h0020;
      bus.b_req_valid = 1'b1;
      bus.b_req_we    = 1'b0;
      bus.b_req_addr  = 15'h0021;
      for (int i = 0; i < 6; i++) begin
         exp_b = RrEn ? (i % 2 == 0) : 1'b1;
         #1;
         n_tests++;
         if (bus.b_req_ready !== exp_b || bus.a_req_ready !== !exp_b) begin
            n_fail++;
            $display("FAIL arb_grant[%0d]: got a=%b b=%b want a=%b b=%b", i,
                     bus.a_req_ready, bus.b_req_ready, !exp_b, exp_b);
         end
         prev_b = exp_b;
         @(negedge clk);
         n_tests++;
         if (bus.b_rsp_valid !== prev_b || bus.a_rsp_valid !== !prev_b ||
             bus.a_rsp_data !== (prev_b ? 16'h3333 : 16'h2222)) begin
            n_fail++;
            $display("FAIL arb_rsp[%0d]: got a_vld=%b b_vld=%b data=%h want b_vld=%b", i,
                     bus.a_rsp_valid, bus.b_rsp_valid, bus.a_rsp_data, prev_b);
         end
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_stall();
      apply_reset();
      do_write(15'h7FFF, 16'hBEEF);
      bus.a_rsp_ready = 1'b0;
      bus.a_req_valid = 1'b1;
      bus.a_req_addr  = 15'h7FFF;
      @(negedge clk);
      bus.a_req_valid = 1'b0;
      bus.b_req_valid = 1'b1;
      bus.b_req_we    = 1'b1;
      bus.b_req_addr  = 15'h7FFF;
      bus.b_req_wdata = 16'h0000;
      #1;
      n_tests++;
      if (!(bus.b_req_ready === 1'b1 && mem_we === 1'b1 && bus.a_rsp_valid === 1'b1)) begin
         n_fail++;
         $display("FAIL stall_write: got b_rdy=%b we=%b a_vld=%b want 1 1 1",
                  bus.b_req_ready, mem_we, bus.a_rsp_valid);
      end
      @(negedge clk);
      bus.b_req_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++;
         if (!(bus.b_req_ready === 1'b0 && mem_re === 1'b0 && bus.a_rsp_valid === 1'b1 &&
               bus.a_rsp_data === 16'hBEEF)) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got b_rdy=%b re=%b a_vld=%b data=%h want 0 0 1 beef",
                     i, bus.b_req_ready, mem_re, bus.a_rsp_valid, bus.a_rsp_data);
         end
         @(negedge clk);
      end
      bus.a_rsp_ready = 1'b1;
      #1;
      n_tests++;
      if (!(bus.b_req_ready === 1'b1 && mem_re === 1'b1 && bus.a_rsp_data === 16'hBEEF)) begin
         n_fail++;
         $display("FAIL stall_release: got b_rdy=%b re=%b data=%h want 1 1 beef",
                  bus.b_req_ready, mem_re, bus.a_rsp_data);
      end
      @(negedge clk);
      bus.b_req_valid = 1'b0;
      n_tests++;
      if (!(bus.a_rsp_valid === 1'b0 && bus.b_rsp_valid === 1'b1 &&
            bus.b_rsp_data === 16'h0000)) begin
         n_fail++;
         $display("FAIL stall_b_rsp: got a_vld=%b b_vld=%b data=%h want 0 1 0000",
                  bus.a_rsp_valid, bus.b_rsp_valid, bus.b_rsp_data);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_data;
      apply_reset();
      for (int i = 0; i < 4; i++) do_write(AW'(i), DW'(16'h0100 + i));
      bus.a_rsp_ready = 1'b1;
      bus.a_req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.a_req_addr = AW'(i);
         #1;
         n_tests++;
         if (bus.a_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.a_req_ready);
         end
         @(negedge clk);
         exp_data = DW'(16'h0100 + i);
         n_tests++;
         if (bus.a_rsp_valid !== 1'b1 || bus.a_rsp_data !== exp_data) begin
            n_fail++;
            $display("FAIL b2b_rsp[%0d]: got vld=%b data=%h want 1 %h", i,
                     bus.a_rsp_valid, bus.a_rsp_data, exp_data);
         end
      end
      bus.a_req_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.a_rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: got vld=%b want 0", bus.a_rsp_valid);
      end
   endtask

   task automatic test_reset_pend();
      apply_reset();
      bus.a_rsp_ready = 1'b0;
      bus.a_req_valid = 1'b1;
      bus.a_req_addr  = 15'h0001;
      @(negedge clk);
      bus.a_req_valid = 1'b0;
      n_tests++;
      if (bus.a_rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstpend_setup: got a_vld=%b want 1", bus.a_rsp_valid);
      end
      rst = 1'b1;
      bus.b_req_valid = 1'b1;
      bus.b_req_we    = 1'b1;
      bus.a_rsp_ready = 1'b1;
      #1;
      n_tests++;
      if ({mem_we, mem_re, bus.a_req_ready, bus.b_req_ready} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rstpend_quiet: got we/re/rdy_a/rdy_b=%b want 0000",
                  {mem_we, mem_re, bus.a_req_ready, bus.b_req_ready});
      end
      @(negedge clk);
      rst = 1'b0;
      bus.b_req_we    = 1'b0;
      bus.b_req_addr  = 15'h0002;
      bus.a_rsp_ready = 1'b0;
      bus.b_rsp_ready = 1'b0;
      #1;
      n_tests++;
      if (!(bus.a_rsp_valid === 1'b0 && bus.b_rsp_valid === 1'b0 &&
            bus.b_req_ready === 1'b1)) begin
         n_fail++;
         $display("FAIL rstpend_idle: got a_vld=%b b_vld=%b b_rdy=%b want 0 0 1",
                  bus.a_rsp_valid, bus.b_rsp_valid, bus.b_req_ready);
      end
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
   endtask

   initial begin
      clk     = 1'b0;
      rst     = 1'b1;
      n_tests = 0;
      n_fail  = 0;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_arbitration();
      test_stall();
      test_back_to_back();
      test_reset_pend();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
